// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receive tracker: default code width,
// tracker FSM states and a reference Gray-to-binary decode function.
package gray_pkg;

  localparam int unsigned GrayWidth = 3;

  typedef enum logic [0:0] {
    StEmpty,
    StTrack
  } track_state_e;

  // Reference decode for the default width: each binary bit is the XOR of all
  // Gray bits at or above its position.
  function automatic logic [GrayWidth-1:0] gray2bin(input logic [GrayWidth-1:0] g);
    logic [GrayWidth-1:0] b;
    for (int i = 0; i < int'(GrayWidth); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Pure combinational Gray-to-binary decoder of configurable width.
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GrayWidth
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB down: bin[i] = ^gray[WIDTH-1:i].
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Receive-side Gray sample tracker: decodes incoming Gray codes, reports the
// modular step from the previous sample and counts max->0 wraps, presenting
// each record through a single-entry valid/ready output register.
// Optional feature: define GRAY_STEP_CHECK_EN to flag (sticky) any Gray sample
// that differs from its predecessor in more than one bit.
module gray_to_binary_tracker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = GrayWidth,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_gray,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_bin,
  output logic [WIDTH-1:0]  out_step,
  output logic              out_first,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err
);

  localparam logic [WIDTH-1:0]  MaxBin  = '1;
  localparam logic [WRAP_W-1:0] WrapMax = '1;

  track_state_e      state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_bin_q, out_bin_d;
  logic [WIDTH-1:0]  out_step_q, out_step_d;
  logic              out_first_q, out_first_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH-1:0]  prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0]  in_bin;
  logic              accept;

  gray2bin_comb #(
    .WIDTH(WIDTH)
  ) u_decode (
    .gray(in_gray),
    .bin (in_bin)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state for FSM, output record, history and wrap counter.
  always_comb begin
    state_d     = state_q;
    out_bin_d   = out_bin_q;
    out_step_d  = out_step_q;
    out_first_d = out_first_q;
    wrap_cnt_d  = wrap_cnt_q;
    prev_bin_d  = prev_bin_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      out_valid_d = 1'b1;
      out_bin_d   = in_bin;
      prev_bin_d  = in_bin;
      state_d     = StTrack;
      unique case (state_q)
        StEmpty: begin
          out_step_d  = '0;
          out_first_d = 1'b1;
        end
        StTrack: begin
          out_step_d  = in_bin - prev_bin_q;
          out_first_d = 1'b0;
          // Saturate rather than roll over so a long run never looks small.
          if (prev_bin_q == MaxBin && in_bin == '0 && wrap_cnt_q != WrapMax) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_step_q  <= '0;
      out_first_q <= 1'b0;
      wrap_cnt_q  <= '0;
      prev_bin_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_step_q  <= out_step_d;
      out_first_q <= out_first_d;
      wrap_cnt_q  <= wrap_cnt_d;
      prev_bin_q  <= prev_bin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_step  = out_step_q;
  assign out_first = out_first_q;
  assign wrap_cnt  = wrap_cnt_q;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0] gray_diff;
  logic             multi_bit;
  logic             step_err_q, step_err_d;

  assign gray_diff = in_gray ^ prev_gray_q;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_bit = (gray_diff & (gray_diff - WIDTH'(1))) != '0;

  // Track previous Gray code and latch any multi-bit transition.
  always_comb begin
    prev_gray_d = prev_gray_q;
    step_err_d  = step_err_q;
    if (accept) begin
      prev_gray_d = in_gray;
      if (state_q == StTrack && multi_bit) begin
        step_err_d = 1'b1;
      end
    end
  end

  // Step-check history and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      step_err_q  <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      step_err_q  <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Scoreboard bench for gray_to_binary_tracker (WIDTH=3, WRAP_W=8).
module tb_gray_to_binary_tracker;

  typedef struct packed {
    logic [2:0] bin;
    logic [2:0] step;
    logic       first;
    logic [7:0] wrap;
    logic       err;
  } rec_t;

`ifdef GRAY_STEP_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_gray = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_bin;
  logic [2:0] out_step;
  logic       out_first;
  logic [7:0] wrap_cnt;
  logic       step_err;

  rec_t       exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [2:0] gray_of [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                              3'b110, 3'b111, 3'b101, 3'b100};

  gray_to_binary_tracker #(
    .WIDTH (3),
    .WRAP_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_gray  (in_gray),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bin  (out_bin),
    .out_step (out_step),
    .out_first(out_first),
    .wrap_cnt (wrap_cnt),
    .step_err (step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input int b, input int s, input int f, input int w, input int e);
    rec_t r;
    r.bin   = 3'(b);
    r.step  = 3'(s);
    r.first = 1'(f);
    r.wrap  = 8'(w);
    r.err   = 1'(e);
    return r;
  endfunction

  // Offer one sample; expected record is queued once the DUT accepts it.
  task automatic send(input logic [2:0] g, input rec_t exp);
    int  n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_gray  = g;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else exp_q.push_back(exp);
    in_valid = 1'b0;
  endtask

  // Monitor: every output handshake pops one expected record.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("out_bin", int'(out_bin), int'(e.bin));
        chk("out_step", int'(out_step), int'(e.step));
        chk("out_first", int'(out_first), int'(e.first));
        chk("wrap_cnt", int'(wrap_cnt), int'(e.wrap));
        chk("step_err", int'(step_err), int'(e.err));
      end
    end
  end

  initial begin
    int w;
    int b;
    // Reset state.
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_bin", int'(out_bin), 0);
    chk("rst_out_first", int'(out_first), 0);
    chk("rst_wrap_cnt", int'(wrap_cnt), 0);
    chk("rst_step_err", int'(step_err), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: count 0..7.
    for (int i = 0; i < 8; i++) begin
      send(gray_of[i], mk(i, (i == 0) ? 0 : 1, (i == 0) ? 1 : 0, 0, 0));
    end
    // 2: first wrap, then 8 full loops.
    send(3'b000, mk(0, 1, 0, 1, 0));
    w = 1;
    for (int l = 0; l < 8; l++) begin
      for (int k = 1; k <= 8; k++) begin
        b = k % 8;
        if (b == 0) w++;
        send(gray_of[b], mk(b, 1, 0, w, 0));
      end
    end
    // 4: forward jump 0->3, then backwards 3->2.
    send(3'b010, mk(3, 3, 0, 9, 0));
    send(3'b011, mk(2, 7, 0, 9, 0));

    // 3: backpressure.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(3'b010, mk(3, 1, 0, 9, 0));
    fork
      begin
        send(3'b110, mk(4, 1, 0, 9, 0));
        send(3'b111, mk(5, 1, 0, 9, 0));
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_out_bin", int'(out_bin), 3);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    chk("stall_drain_len", exp_q.size() <= 1 ? 1 : 0, 1);

    // 5: multi-bit Gray transition (reach 000 by single-bit steps first).
    send(3'b101, mk(6, 1, 0, 9, 0));
    send(3'b100, mk(7, 1, 0, 9, 0));
    send(3'b000, mk(0, 1, 0, 10, 0));
    send(3'b011, mk(2, 2, 0, 10, int'(ChkEn)));
    send(3'b010, mk(3, 1, 0, 10, int'(ChkEn)));

    // 6: reset with a record held on the output.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(3'b110, mk(4, 1, 0, 10, int'(ChkEn)));
    chk("pre_rst_out_valid", int'(out_valid), 1);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_wrap_cnt", int'(wrap_cnt), 0);
    chk("midrst_step_err", int'(step_err), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(3'b011, mk(2, 0, 1, 0, 0));
    send(3'b010, mk(3, 1, 0, 0, 0));

    // Drain the scoreboard.
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
